// File: rtl/s8_jkcnt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : s8_pkg
//  Purpose  : Shared constants for the JK-cell counter: the {J,K} command
//             encodings understood by jk_cell and the decade terminal value.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package s8_pkg;

   // {J,K} command encodings
   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_CLR  = 2'b01;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_TOG  = 2'b11;

   // Highest value of a decade (BCD) digit
   localparam logic [3:0] BCD_MAX = 4'd9;

endpackage : s8_pkg
`default_nettype wire

// File: rtl/s8_jkcnt_jk_cell.sv
`default_nettype none
// ============================================================================
//  Module   : jk_cell
//  Purpose  : Single JK flip-flop with asynchronous active-low clear.
//  Ports    : clk  - clock, state changes on rising edge
//             rst  - asynchronous active-low clear
//             j, k - command: hold / clear / set / toggle
//             q    - cell output
//             qb   - complement of q
//  Revision : 1.0  initial release
// ============================================================================
module jk_cell
   import s8_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic j,
   input  logic k,
   output logic q,
   output logic qb
);

   logic q_q;
   logic q_d;

   always_comb begin
      q_d = q_q;
      case ({j, k})
         JK_HOLD: q_d = q_q;
         JK_CLR:  q_d = 1'b0;
         JK_SET:  q_d = 1'b1;
         JK_TOG:  q_d = ~q_q;
         default: q_d = q_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q  = q_q;
   assign qb = ~q_q;

endmodule : jk_cell
`default_nettype wire

// File: rtl/s8_jkcnt.sv
`default_nettype none
// ============================================================================
//  Module   : s8_jkcnt
//  Purpose  : Synchronous up/down counter built from WIDTH jk_cell stages.
//             The top level only generates each cell's J/K command and the
//             combinational terminal-count flag; all state lives in the cells.
//  Config   : S8_JKCNT_BCD_EN - when defined, decade counting (WIDTH must be 4)
//  Ports    : clk  - counter clock
//             rst  - asynchronous active-low reset
//             en   - count enable
//             up   - direction, 1 = increment, 0 = decrement
//             load - synchronous parallel load, overrides en
//             din  - value to load
//             q    - current count
//             tc   - terminal count (combinational)
//  Revision : 1.0  initial release
// ============================================================================
module s8_jkcnt
   import s8_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q,
   output logic             tc
);

`ifdef S8_JKCNT_BCD_EN
   if (WIDTH != 4) begin : g_bcd_width_err
      $error("s8_jkcnt: decade mode requires WIDTH == 4");
   end
`endif

   logic [WIDTH-1:0] w_j;
   logic [WIDTH-1:0] w_k;
   logic [WIDTH-1:0] w_qb;
   logic [WIDTH-1:0] w_all1;   // w_all1[i]: q[i-1:0] all ones
   logic [WIDTH-1:0] w_all0;   // w_all0[i]: q[i-1:0] all zeros
   logic [WIDTH-1:0] w_tog;
   logic             w_term;

   // Carry/borrow chains: a cell toggles once every lower cell is at the
   // value that carries (up) or borrows (down). Cell 0 always toggles.
   always_comb begin
      w_all1    = '0;
      w_all0    = '0;
      w_all1[0] = 1'b1;
      w_all0[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         w_all1[i] = w_all1[i-1] & q[i-1];
         w_all0[i] = w_all0[i-1] & w_qb[i-1];
      end
   end

   assign w_tog = up ? w_all1 : w_all0;

   always_comb begin
      w_j = '0;
      w_k = '0;
      if (load) begin
         w_j = din;
         w_k = ~din;
      end else if (en) begin
         w_j = w_tog;
         w_k = w_tog;
`ifdef S8_JKCNT_BCD_EN
         // Decade wrap overrides the binary toggle pattern: 9 (or any
         // out-of-range load value) clears to 0, and 0 counting down sets 9.
         if ((up && (q >= WIDTH'(BCD_MAX))) || (!up && (q > WIDTH'(BCD_MAX)))) begin
            w_j = '0;
            w_k = '1;
         end else if (!up && (&w_qb)) begin
            w_j = WIDTH'(BCD_MAX);
            w_k = ~WIDTH'(BCD_MAX);
         end
`endif
      end
   end

`ifdef S8_JKCNT_BCD_EN
   assign w_term = up ? (q == WIDTH'(BCD_MAX)) : (&w_qb);
`else
   assign w_term = up ? (&q) : (&w_qb);
`endif

   assign tc = en & ~load & w_term;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      jk_cell u_cell (
         .clk (clk),
         .rst (rst),
         .j   (w_j[gi]),
         .k   (w_k[gi]),
         .q   (q[gi]),
         .qb  (w_qb[gi])
      );
   end

endmodule : s8_jkcnt
`default_nettype wire

// File: tb/tb_s8_jkcnt.sv
`default_nettype none
// ============================================================================
//  Module   : tb_s8_jkcnt
//  Purpose  : Self-checking bench for s8_jkcnt (WIDTH = 4). Expected counts
//             are pushed when stimulus is applied and popped after the edge.
//  Config   : S8_JKCNT_BCD_EN selects the decade-mode scenarios and model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_s8_jkcnt;

   localparam int W = 4;

   logic         clk  = 1'b0;
   logic         rst  = 1'b0;
   logic         en   = 1'b0;
   logic         up   = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] din  = '0;
   logic [W-1:0] q;
   logic         tc;

   int n_checks = 0;
   int n_pass   = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] m_q = '0;

   always #5 clk = ~clk;

   s8_jkcnt #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .up   (up),
      .load (load),
      .din  (din),
      .q    (q),
      .tc   (tc)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs === expv) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
   endtask

   function automatic logic [W-1:0] model_next(input logic [W-1:0] cur, input logic i_en,
                                              input logic i_up, input logic i_load,
                                              input logic [W-1:0] i_din);
      if (i_load) return i_din;
      if (!i_en)  return cur;
`ifdef S8_JKCNT_BCD_EN
      if (i_up) return (cur >= 4'd9) ? 4'd0 : cur + 4'd1;
      if (cur == 4'd0) return 4'd9;
      if (cur > 4'd9)  return 4'd0;
      return cur - 4'd1;
`else
      return i_up ? cur + 1'b1 : cur - 1'b1;
`endif
   endfunction

   function automatic logic model_tc(input logic [W-1:0] cur, input logic i_en,
                                     input logic i_up, input logic i_load);
      logic term;
`ifdef S8_JKCNT_BCD_EN
      term = i_up ? (cur == 4'd9) : (cur == 4'd0);
`else
      term = i_up ? (cur == 4'hF) : (cur == 4'd0);
`endif
      return i_en & ~i_load & term;
   endfunction

   // Called just after a rising edge: apply inputs, check tc, push the
   // expected count, then pop and compare after the next edge.
   task automatic step(input string tag, input logic i_en, input logic i_up,
                       input logic i_load, input logic [W-1:0] i_din);
      logic [W-1:0] nxt;
      en = i_en; up = i_up; load = i_load; din = i_din;
      #1;
      check_val({tag, "_tc"}, 32'(tc), 32'(model_tc(m_q, i_en, i_up, i_load)));
      nxt = model_next(m_q, i_en, i_up, i_load, i_din);
      exp_q.push_back(nxt);
      m_q = nxt;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) check_val({tag, "_sb_empty"}, 32'd1, 32'd0);
      else check_val(tag, 32'(q), 32'(exp_q.pop_front()));
   endtask

   initial begin
      // Reset state
      #2;
      check_val("rst_q", 32'(q), 32'd0);
      en = 1'b1; up = 1'b0; load = 1'b0;
      #1 check_val("rst_tc_dn", 32'(tc), 32'd1);
      up = 1'b1;
      #1 check_val("rst_tc_up", 32'(tc), 32'd0);
      @(posedge clk); #1;
      check_val("rst_hold_q", 32'(q), 32'd0);
      rst = 1'b1;
      m_q = '0;

`ifdef S8_JKCNT_BCD_EN
      step("ld8",      1'b0, 1'b1, 1'b1, 4'd8);
      step("bcd_up9",  1'b1, 1'b1, 1'b0, 4'd0);
      step("bcd_up0",  1'b1, 1'b1, 1'b0, 4'd0);
      step("bcd_dn9",  1'b1, 1'b0, 1'b0, 4'd0);
      step("bcd_dn8",  1'b1, 1'b0, 1'b0, 4'd0);
      step("ld12",     1'b0, 1'b1, 1'b1, 4'd12);
      step("bcd_ov_up",1'b1, 1'b1, 1'b0, 4'd0);
      step("ld15",     1'b0, 1'b1, 1'b1, 4'd15);
      step("bcd_ov_dn",1'b1, 1'b0, 1'b0, 4'd0);
`else
      step("ld14",     1'b0, 1'b1, 1'b1, 4'd14);
      step("up15",     1'b1, 1'b1, 1'b0, 4'd0);
      step("up_wrap",  1'b1, 1'b1, 1'b0, 4'd0);
      step("dn_wrap",  1'b1, 1'b0, 1'b0, 4'd0);
      step("dn14",     1'b1, 1'b0, 1'b0, 4'd0);
      step("ld15",     1'b0, 1'b1, 1'b1, 4'd15);
      step("ld_tc15",  1'b1, 1'b1, 1'b1, 4'd15);
`endif
      // Load priority over enable
      step("ld3",      1'b0, 1'b1, 1'b1, 4'd3);
      step("ld_pri",   1'b1, 1'b1, 1'b1, 4'b1010);
      // Hold and direction change
      step("ld5",      1'b0, 1'b1, 1'b1, 4'd5);
      for (int i = 0; i < 3; i++) step("hold", 1'b0, 1'b1, 1'b0, 4'd0);
      step("dir_up",   1'b1, 1'b1, 1'b0, 4'd0);
      step("dir_dn",   1'b1, 1'b0, 1'b0, 4'd0);
      step("dir_up2",  1'b1, 1'b1, 1'b0, 4'd0);

      // Asynchronous reset in the middle of a count
      step("ld6",      1'b0, 1'b1, 1'b1, 4'd6);
      en = 1'b1; up = 1'b1; load = 1'b0;
      #2 rst = 1'b0;
      #1 check_val("async_rst_q", 32'(q), 32'd0);
      @(posedge clk); #1;
      check_val("rst_held_q", 32'(q), 32'd0);
      rst = 1'b1;
      m_q = '0;
      step("post_rst", 1'b1, 1'b1, 1'b0, 4'd0);

      // Random mix
      for (int i = 0; i < 40; i++) begin
         step("rand", 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
              W'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_s8_jkcnt
`default_nettype wire
